// File: rtl/regs_shift_deserializer.sv
// Serial-to-parallel shift register: p_lanes bits per input transfer, p_nbits-bit
// words on a held valid/ready output. Define REGS_SHIFT_DESER_PARITY_EN for out_parity.
module regs_shift_deserializer #(
  parameter int                 p_nbits       = 8,
  parameter int                 p_lanes       = 1,
  parameter bit                 p_msb_first   = 1'b1,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  in_val,
  output logic                                  in_rdy,
  input  logic [p_lanes-1:0]                    in_data,
  output logic                                  out_val,
  input  logic                                  out_rdy,
  output logic [p_nbits-1:0]                    out_data,
  output logic [$clog2(p_nbits/p_lanes):0]      count
`ifdef REGS_SHIFT_DESER_PARITY_EN
  ,
  output logic                                  out_parity
`endif
);

  localparam int n_sym = p_nbits / p_lanes;
  localparam int cw    = $clog2(n_sym) + 1;

  localparam logic [cw-1:0] last_cnt = cw'(n_sym - 1);
  localparam logic [cw-1:0] cnt_one  = cw'(1);

  logic [p_nbits-1:0] sr;
  logic [p_nbits-1:0] sr_next;
  logic [cw-1:0]      cnt;
  logic               is_last;
  logic               in_fire;
  logic               out_fire;

  assign is_last  = (cnt == last_cnt);
  // Stall only when the final symbol would overwrite a word nobody has taken yet.
  assign in_rdy   = ~clear & (~is_last | ~out_val | out_rdy);
  assign in_fire  = in_val & in_rdy;
  assign out_fire = out_val & out_rdy;
  assign count    = cnt;

  // NOTE: always_comb assigns a default first so no path leaves sr_next unassigned (no latch).
  always_comb begin
    sr_next = sr;
    if (p_msb_first)
      sr_next = {sr[p_nbits-p_lanes-1:0], in_data};
    else
      sr_next = {in_data, sr[p_nbits-1:p_lanes]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr       <= p_reset_value;
      cnt      <= '0;
      out_val  <= 1'b0;
      out_data <= p_reset_value;
    end else if (clear) begin
      // Flush partial and pending words; the last delivered value stays on out_data.
      sr      <= p_reset_value;
      cnt     <= '0;
      out_val <= 1'b0;
    end else begin
      if (out_fire)
        out_val <= 1'b0;
      if (in_fire) begin
        sr <= sr_next;
        if (is_last) begin
          out_data <= sr_next;
          out_val  <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + cnt_one;
        end
      end
    end
  end

`ifdef REGS_SHIFT_DESER_PARITY_EN
  // Parity is captured alongside out_data, so it shares its hold and clear behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      out_parity <= 1'b0;
    else if (!clear && in_fire && is_last)
      out_parity <= ^sr_next;
  end
`endif

endmodule

// File: tb/tb_regs_shift_deserializer.sv
// Directed bench: msb-first 1-lane and lsb-first 2-lane instances with hand-computed words.
module tb_regs_shift_deserializer;

  logic clk;
  logic reset;

  // Instance a: p_nbits=8, p_lanes=1, msb-first
  logic       a_clear, a_in_val, a_in_rdy, a_out_val, a_out_rdy;
  logic [0:0] a_in_data;
  logic [7:0] a_out_data;
  logic [3:0] a_count;
`ifdef REGS_SHIFT_DESER_PARITY_EN
  logic       a_out_parity;
  logic       b_out_parity;
`endif

  // Instance b: p_nbits=8, p_lanes=2, lsb-first
  logic       b_clear, b_in_val, b_in_rdy, b_out_val, b_out_rdy;
  logic [1:0] b_in_data;
  logic [7:0] b_out_data;
  logic [2:0] b_count;

  int compared   = 0;
  int mismatched = 0;

  regs_shift_deserializer #(
    .p_nbits(8), .p_lanes(1), .p_msb_first(1'b1), .p_reset_value(8'h00)
  ) dut_a (
    .clk(clk), .reset(reset), .clear(a_clear),
    .in_val(a_in_val), .in_rdy(a_in_rdy), .in_data(a_in_data),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out_data(a_out_data),
    .count(a_count)
`ifdef REGS_SHIFT_DESER_PARITY_EN
    , .out_parity(a_out_parity)
`endif
  );

  regs_shift_deserializer #(
    .p_nbits(8), .p_lanes(2), .p_msb_first(1'b0), .p_reset_value(8'h00)
  ) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear),
    .in_val(b_in_val), .in_rdy(b_in_rdy), .in_data(b_in_data),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_data(b_out_data),
    .count(b_count)
`ifdef REGS_SHIFT_DESER_PARITY_EN
    , .out_parity(b_out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed the first nsym bits of w (MSB first) into instance a, checking acceptance and count.
  task automatic send_a(input string tag, input logic [7:0] w, input int nsym, input int start);
    for (int i = 0; i < nsym; i++) begin
      a_in_val  = 1'b1;
      a_in_data = w[7-i];
      #1;
      check($sformatf("%s_rdy%0d", tag, i), {31'd0, a_in_rdy}, 32'd1);
      check($sformatf("%s_cnt%0d", tag, i), {28'd0, a_count}, start + i);
      @(posedge clk);
      #1;
    end
    a_in_val = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    a_clear = 1'b0; a_in_val = 1'b0; a_in_data = '0; a_out_rdy = 1'b1;
    b_clear = 1'b0; b_in_val = 1'b0; b_in_data = '0; b_out_rdy = 1'b1;
    step();
    step();

    // Reset state
    check("rst_a_val",  {31'd0, a_out_val}, 32'd0);
    check("rst_a_cnt",  {28'd0, a_count},   32'd0);
    check("rst_a_data", {24'd0, a_out_data}, 32'h00);
    check("rst_a_rdy",  {31'd0, a_in_rdy},  32'd1);
    check("rst_b_data", {24'd0, b_out_data}, 32'h00);
    reset = 1'b1;
    step();

    // Word 8'hB2 msb-first, consumer always ready
    send_a("w1", 8'hB2, 8, 0);
    check("w1_val",  {31'd0, a_out_val},  32'd1);
    check("w1_data", {24'd0, a_out_data}, 32'hB2);
    check("w1_cnt",  {28'd0, a_count},    32'd0);
`ifdef REGS_SHIFT_DESER_PARITY_EN
    check("w1_par",  {31'd0, a_out_parity}, 32'd0);
`endif
    step();
    check("w1_drop", {31'd0, a_out_val}, 32'd0);

    // lsb-first, 2 lanes: 01,10,11,00 -> 8'h39
    b_in_val = 1'b1;
    b_in_data = 2'b01; step();
    b_in_data = 2'b10; step();
    b_in_data = 2'b11; step();
    check("b_cnt3", {29'd0, b_count}, 32'd3);
    b_in_data = 2'b00; step();
    b_in_val = 1'b0;
    check("b_val",  {31'd0, b_out_val},  32'd1);
    check("b_data", {24'd0, b_out_data}, 32'h39);
    check("b_cnt0", {29'd0, b_count},    32'd0);

    // Backpressure: B2 pending, next word 8'h5C stalls on its final bit
    a_out_rdy = 1'b0;
    send_a("bp1", 8'hB2, 8, 0);
    check("bp_pend_val",  {31'd0, a_out_val},  32'd1);
    check("bp_pend_data", {24'd0, a_out_data}, 32'hB2);
    send_a("bp2", 8'h5C, 7, 0);
    check("bp_cnt7", {28'd0, a_count}, 32'd7);
    a_in_val  = 1'b1;
    a_in_data = 1'b0;
    #1;
    check("bp_stall_rdy", {31'd0, a_in_rdy}, 32'd0);
    step();
    check("bp_hold_cnt",  {28'd0, a_count},    32'd7);
    check("bp_hold_data", {24'd0, a_out_data}, 32'hB2);
    check("bp_hold_val",  {31'd0, a_out_val},  32'd1);
    a_out_rdy = 1'b1;
    #1;
    check("bp_release_rdy", {31'd0, a_in_rdy}, 32'd1);
    step();
    a_in_val = 1'b0;
    check("bp_new_val",  {31'd0, a_out_val},  32'd1);
    check("bp_new_data", {24'd0, a_out_data}, 32'h5C);
    check("bp_new_cnt",  {28'd0, a_count},    32'd0);
    step();
    check("bp_drained", {31'd0, a_out_val}, 32'd0);

    // Clear at count 5 with 8'hA5 pending
    a_out_rdy = 1'b0;
    send_a("cl1", 8'hA5, 8, 0);
    send_a("cl2", 8'hFF, 5, 0);
    check("cl_cnt5", {28'd0, a_count}, 32'd5);
    a_clear   = 1'b1;
    a_in_val  = 1'b1;
    a_in_data = 1'b1;
    #1;
    check("cl_rdy", {31'd0, a_in_rdy}, 32'd0);
    step();
    a_clear  = 1'b0;
    a_in_val = 1'b0;
    check("cl_cnt",  {28'd0, a_count},    32'd0);
    check("cl_val",  {31'd0, a_out_val},  32'd0);
    check("cl_data", {24'd0, a_out_data}, 32'hA5);
    a_out_rdy = 1'b1;
    send_a("cl3", 8'h3C, 8, 0);
    check("cl_word_val",  {31'd0, a_out_val},  32'd1);
    check("cl_word_data", {24'd0, a_out_data}, 32'h3C);

    // Async reset between edges, mid-word, with a word pending
    a_out_rdy = 1'b0;
    send_a("ar", 8'hE0, 3, 0);
    check("ar_pre_cnt", {28'd0, a_count},   32'd3);
    check("ar_pre_val", {31'd0, a_out_val}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_val",  {31'd0, a_out_val},  32'd0);
    check("ar_cnt",  {28'd0, a_count},    32'd0);
    check("ar_data", {24'd0, a_out_data}, 32'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fresh word 8'h01 after reset
    a_out_rdy = 1'b1;
    send_a("w2", 8'h01, 8, 0);
    check("w2_val",  {31'd0, a_out_val},  32'd1);
    check("w2_data", {24'd0, a_out_data}, 32'h01);
`ifdef REGS_SHIFT_DESER_PARITY_EN
    check("w2_par",  {31'd0, a_out_parity}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regs_shift_deserializer.md
# regs_shift_deserializer

Parametrised serial-to-parallel shift register. It accepts `p_lanes` bits per transfer on a valid/ready input and assembles them into `p_nbits`-bit words. Each completed word goes to a held output register with its own valid/ready handshake, so the next word can fill while the current one waits. It sits between serial front-ends (SPI/I2S-style bit streams, multi-lane serial links) and word-wide datapaths, and generalises the single-bit enable-gated shift register to lanes, bit order and flow control.

## Interface
Parameters:
- `p_nbits`, 8: output word width; must be a multiple of `p_lanes` and at least 2·`p_lanes`.
- `p_lanes`, 1: serial bits accepted per transfer.
- `p_msb_first`, 1: 1 = first symbol lands in the word MSBs; 0 = first symbol lands in the word LSBs.
- `p_reset_value`, 0: `p_nbits`-wide reset/clear value of the shift and output registers.

Ports:
- `clk` input 1: clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0); deassertion is synchronous to `clk` externally.
- `clear` input 1: synchronous flush of partial and pending data.
- `in_val` input 1: input symbol valid.
- `in_rdy` output 1: block can accept a symbol.
- `in_data` input `p_lanes`: input symbol.
- `out_val` output 1: `out_data` holds a completed word.
- `out_rdy` input 1: consumer accepts word.
- `out_data` output `p_nbits`: assembled word, registered.
- `count` output `$clog2(p_nbits/p_lanes)+1`: symbols held in the partial word, range 0..N-1, where N = `p_nbits`/`p_lanes`.
- `out_parity` output 1: present only with `REGS_SHIFT_DESER_PARITY_EN`.

## Operation
- State: shift register `sr`, symbol counter `cnt` (drives `count`), output register `out_data`, flag `out_val`.
- Reset (`reset`=0, immediate): `sr`=`out_data`=`p_reset_value`, `cnt`=0, `out_val`=0, `out_parity`=0.
- The input transfer fires on `in_val & in_rdy`.
- `in_rdy` = `~clear & (cnt != N-1 | ~out_val | out_rdy)`. The block stalls only when the final symbol would overwrite a pending, unconsumed word.
- Shift on a non-final transfer (`cnt` < N-1):
  - msb-first: `sr` <= {`sr`[p_nbits-p_lanes-1:0], `in_data`}.
  - lsb-first: `sr` <= {`in_data`, `sr`[p_nbits-1:p_lanes]}.
  - `cnt` increments.
- Final transfer (`cnt`==N-1):
  - The shifted word, including the current `in_data`, is written to `out_data`.
  - `out_val` <= 1 and `cnt` <= 0.
  - `sr` keeps the shifted value; it is overwritten by later symbols.
- Output transfer fires on `out_val & out_rdy`: `out_val` <= 0, unless a final input transfer happens in the same cycle, in which case `out_val` stays 1 with the new word.
- `out_data` is stable while `out_val`=1 and `out_rdy`=0.
- `clear`=1 takes priority over every other update: `sr`=`p_reset_value`, `cnt`=0, `out_val`=0, `out_data` unchanged. A symbol presented during `clear` is not accepted because `in_rdy`=0.
- Wrap-around: `cnt` never reaches N; each word boundary is exact.

## Timing
- Latency: `out_val` rises in the cycle after the final symbol transfer.
- Throughput: one symbol per cycle sustained when `out_rdy` is 1 at each word boundary.
- `in_rdy` depends combinationally on `out_rdy`, `out_val`, `cnt` and `clear`; there is no path from `in_val` to `in_rdy`.
- Reset asserted mid-word discards the partial word and the pending word immediately; the first cycle after deassertion starts a fresh word.

## Configuration
- `REGS_SHIFT_DESER_PARITY_EN` defined:
  - `out_parity` port exists and carries the even parity (XOR reduction) of the word.
  - It is registered together with `out_data` and has identical timing and hold behaviour.
  - It is unchanged by `clear`.
- Not defined: no `out_parity` port and no parity logic; all other behaviour is identical.

## Test plan
- Reset, then msb-first, `p_nbits`=8, `p_lanes`=1, `out_rdy`=1; feed bits 1,0,1,1,0,0,1,0 on consecutive cycles -> `out_val`=1 for one cycle after the 8th, `out_data`=8'hB2, `count` cycles 0..7 then 0.
- `p_msb_first`=0, `p_lanes`=2, `p_nbits`=8; symbols 2'b01,2'b10,2'b11,2'b00 -> `out_data`=8'h39.
- Backpressure: `out_rdy`=0 with word 8'hB2 pending; stream the next 7 bits -> all accepted, `count`=7, `in_rdy`=0 on the 8th; `out_data` holds 8'hB2. Raise `out_rdy` -> 8th bit accepted that cycle, next cycle `out_val`=1 with the new word, no gap.
- `clear` asserted at `count`=5 with a word pending -> next cycle `count`=0, `out_val`=0, `in_rdy`=0 during `clear`; the next 8 bits form a clean word.
- Async reset: pull `reset` low between clock edges mid-word -> `out_val`, `count` and `out_data` reach reset values before the next edge.
- Parity build: words 8'hB2 and 8'h01 -> `out_parity`=0 for 8'hB2 and 1 for 8'h01; the non-parity build has no `out_parity` port and elaborates cleanly.
